switch_input_ctrl: RTL
======================

// Module: switch_input_ctrl
// PURPOSE
//  Parametrised switch front-end between the board DIP switches and the memory-mapped
//  I/O bus. Synchronises and debounces SW_WIDTH raw switch lines, records sticky
//  rising-edge flags, and returns debounced levels or edge flags one byte lane per read.
//  Read-to-clear edge flags and an interrupt-style summary let software poll or react.
// PARAMETERS
//  SW_WIDTH     24      number of switch inputs; multiple of 8, 8..32
//  DATA_WIDTH   16      width of read bus to CPU; byte lanes are zero-extended
//  DEB_DIV      100000  sample-tick period in switclk cycles (1 ms at 100 MHz), >=2
//  DEB_SAMPLES  3       consecutive equal samples needed to change a debounced bit, 2..8
// PORTS
//  switclk       in   1           system clock; all logic on rising edge
//  switrst       in   1           synchronous, active-high reset
//  switcs        in   1           chip select from memory/IO decoder
//  switread      in   1           read strobe; acts only with switcs
//  switchaddr    in   3           lane select (map below)
//  switch_rdata  in   SW_WIDTH    raw asynchronous switch lines from board
//  switch_wdata  out  DATA_WIDTH  read data to CPU
//  switch_rvalid out  1           1-cycle pulse: switch_wdata updated this cycle
//  switch_level  out  SW_WIDTH    debounced levels (direct, for LEDs/debug)
//  switch_irq    out  1           OR of all rise flags
// BEHAVIOUR
//  Reset (switrst=1 at a clock edge): switch_wdata=0, switch_rvalid=0, switch_level=0,
//   rise flags=0, sync flops=0, sample histories=0, prescaler=0; overrides any read.
//  Sync: 2-flop synchroniser per bit; no logic uses switch_rdata directly.
//  Prescaler: counts 0..DEB_DIV-1, wraps; tick=1 for one cycle when count==DEB_DIV-1.
//  Debounce: on tick each bit shifts its synced value into a DEB_SAMPLES-bit history.
//   All-ones history -> level bit 1; all-zeros -> 0; mixed -> level holds.
//   Worst-case input->level latency: 2 + DEB_SAMPLES*DEB_DIV cycles; glitch shorter
//   than (DEB_SAMPLES-1)*DEB_DIV cycles never changes level.
//  Edge: rise flag[i] set the cycle after level[i] goes 0->1; falling edges not flagged.
//   A switch held high at reset-release produces a rise flag once debounced.
//  Address map (lane n = bits [8n+7:8n]); unused lanes (n >= SW_WIDTH/8) read 0:
//   0..3 -> debounced level lane 0..3;  4..7 -> rise-flag lane 0..3 (read-to-clear).
//  Read: at rising edge with switcs&&switread: switch_wdata <= {zeros, selected byte}
//   (value before this edge's updates), switch_rvalid <= 1. Otherwise switch_wdata
//   holds and switch_rvalid <= 0. Back-to-back reads allowed every cycle.
//  Read-to-clear: flag-lane read clears that lane's 8 flags at the same edge; a flag
//   whose rise event occurs in that same cycle stays set (set wins over clear).
//   Level-lane reads and reads with switcs=0 never clear flags.
//  switch_irq combinational OR of flag registers; no extra latency.
// TESTING (DEB_DIV=4, DEB_SAMPLES=3, SW_WIDTH=24)
//  1 Reset: drive rdata=24'hFFFFFF, hold switrst 5 cycles -> all outputs 0 throughout;
//    release -> level=24'hFFFFFF within 14 cycles, irq=1, read addr 4 -> wdata=16'h00FF.
//  2 Debounce: bit 3 1-cycle and 5-cycle pulses -> level[3] stays 0; hold 20 cycles -> 1.
//  3 Lanes: rdata=24'hA5C33C, settle; read addr 0,1,2,3 -> 16'h003C,16'h00C3,16'h00A5,0;
//    rvalid high exactly one cycle after each read strobe; switcs=0 -> no rvalid.
//  4 Read-to-clear: after rise on bit 9, read addr 5 -> 16'h0002, flags lane 1 cleared,
//    irq=0; second read -> 16'h0000; read addr 1 does not clear flags.
//  5 Collision: time rise of bit 10 to the read-clear cycle of addr 5 -> returned
//    data lacks bit 2, flag[10] remains set, next read addr 5 -> 16'h0004.
//  6 Mid-run reset: assert switrst during a pending debounce and read -> all cleared,
//    rvalid=0; debounce restarts from empty history after release.

Source files
------------

// File: rtl/switch_input_ctrl.sv
// Switch front-end: synchronises and debounces raw DIP switch lines, keeps sticky
// rising-edge flags, and serves levels or flags to the CPU one byte lane per read.
module switch_input_ctrl #(
    parameter int SW_WIDTH    = 24,
    parameter int DATA_WIDTH  = 16,
    parameter int DEB_DIV     = 100000,
    parameter int DEB_SAMPLES = 3
) (
    input  logic                  switclk,
    input  logic                  switrst,
    input  logic                  switcs,
    input  logic                  switread,
    input  logic [2:0]            switchaddr,
    input  logic [SW_WIDTH-1:0]   switch_rdata,
    output logic [DATA_WIDTH-1:0] switch_wdata,
    output logic                  switch_rvalid,
    output logic [SW_WIDTH-1:0]   switch_level,
    output logic                  switch_irq
);
    localparam int PW     = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam int NLANES = SW_WIDTH / 8;

    logic [SW_WIDTH-1:0]                  sync1_q, sync2_q;
    logic [PW-1:0]                        presc_q, presc_d;
    logic                                 tick;
    logic [SW_WIDTH-1:0][DEB_SAMPLES-1:0] hist_q, hist_d;
    logic [SW_WIDTH-1:0]                  level_q, level_d, level_dly_q;
    logic [SW_WIDTH-1:0]                  flag_q, flag_d, rise_evt, clr_mask;
    logic [DATA_WIDTH-1:0]                wdata_q, wdata_d;
    logic                                 rvalid_q, rvalid_d;
    logic                                 rd_en;
    logic [1:0]                           lane;
    logic [31:0]                          lvl_pad, flag_pad;
    logic [7:0]                           byte_sel;

    assign tick    = (presc_q == PW'(DEB_DIV - 1));
    assign presc_d = tick ? '0 : presc_q + PW'(1);

    // Level changes only once the whole sample window agrees; mixed windows hold.
    always_comb begin
        hist_d  = hist_q;
        level_d = level_q;
        if (tick) begin
            for (int i = 0; i < SW_WIDTH; i++) begin
                hist_d[i] = {hist_q[i][DEB_SAMPLES-2:0], sync2_q[i]};
                if (&hist_d[i]) begin
                    level_d[i] = 1'b1;
                end else if (~|hist_d[i]) begin
                    level_d[i] = 1'b0;
                end
            end
        end
    end

    assign rd_en    = switcs && switread;
    assign lane     = switchaddr[1:0];
    assign lvl_pad  = 32'(level_q);
    assign flag_pad = 32'(flag_q);
    assign rise_evt = level_q & ~level_dly_q;

    // Lanes beyond SW_WIDTH fall into the zero padding, so they read as 0.
    always_comb begin
        byte_sel = switchaddr[2] ? flag_pad[{lane, 3'b000} +: 8]
                                 : lvl_pad[{lane, 3'b000} +: 8];
        clr_mask = '0;
        for (int n = 0; n < NLANES; n++) begin
            clr_mask[8*n +: 8] = {8{rd_en && switchaddr[2] && (lane == 2'(n))}};
        end
        // A rise landing on the clearing edge survives: set wins over clear.
        flag_d   = (flag_q & ~clr_mask) | rise_evt;
        wdata_d  = rd_en ? DATA_WIDTH'(byte_sel) : wdata_q;
        rvalid_d = rd_en;
    end

    always_ff @(posedge switclk) begin
        if (switrst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            presc_q     <= '0;
            hist_q      <= '0;
            level_q     <= '0;
            level_dly_q <= '0;
            flag_q      <= '0;
            wdata_q     <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            sync1_q     <= switch_rdata;
            sync2_q     <= sync1_q;
            presc_q     <= presc_d;
            hist_q      <= hist_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            flag_q      <= flag_d;
            wdata_q     <= wdata_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign switch_wdata  = wdata_q;
    assign switch_rvalid = rvalid_q;
    assign switch_level  = level_q;
    assign switch_irq    = |flag_q;

endmodule
